ahb_switch_in: RTL and testbench



---
 rtl/ahb_switch_pkg.sv | 16 +
 rtl/switch_debounce.sv | 45 ++++
 rtl/ahb_switch_in.sv | 131 +++++++++++++
 tb/tb_ahb_switch_in.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_switch_pkg.sv
// Shared register offsets and register-index type for the AHB switch input block.
package ahb_switch_pkg;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_RAW    = 2'd1;
  localparam logic [1:0] ADDR_IRQ_EN = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    REG_DATA   = ADDR_DATA,
    REG_RAW    = ADDR_RAW,
    REG_IRQ_EN = ADDR_IRQ_EN,
    REG_STATUS = ADDR_STATUS
  } reg_idx_t;

endpackage

// File: rtl/switch_debounce.sv
// Per-bit debouncer: three agreeing tick samples update the stable state;
// o_change pulses for one cycle after any stable bit flips.
module switch_debounce #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_raw,
  input  logic             i_tick,
  output logic [WIDTH-1:0] o_stable,
  output logic [WIDTH-1:0] o_change
);

  logic [WIDTH-1:0] r_h1;
  logic [WIDTH-1:0] r_h0;
  logic [WIDTH-1:0] r_stable;
  logic [WIDTH-1:0] r_stable_d;
  logic [WIDTH-1:0] w_agree;

  // A bit agrees when the current sample matches both previous tick samples.
  assign w_agree = ~(i_raw ^ r_h1) & ~(i_raw ^ r_h0);

  // Shift the sample history and update stable bits that agree, on each tick.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h1     <= '0;
      r_h0     <= '0;
      r_stable <= '0;
    end else if (i_tick) begin
      r_h1     <= i_raw;
      r_h0     <= r_h1;
      r_stable <= (r_stable & ~w_agree) | (i_raw & w_agree);
    end
  end

  // One-cycle delayed copy of the stable state for edge detection.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_stable_d <= '0;
    else          r_stable_d <= r_stable;
  end

  assign o_stable = r_stable;
  assign o_change = r_stable ^ r_stable_d;

endmodule

// File: rtl/ahb_switch_in.sv
// AHB-Lite slave for up to 32 switch inputs: synchroniser, debounce tick,
// sticky change flags and a maskable level interrupt.
module ahb_switch_in
  import ahb_switch_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_PERIOD   = 50000,
  parameter int DB_CNT_W    = 16
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HSEL,
  input  logic             HREADY,
  input  logic [31:0]      HADDR,
  input  logic [1:0]       HTRANS,
  input  logic             HWRITE,
  input  logic [2:0]       HSIZE,
  input  logic [31:0]      HWDATA,
  output logic             HREADYOUT,
  output logic [31:0]      HRDATA,
  input  logic [WIDTH-1:0] Switches,
  output logic             IRQ
);

  logic                r_hsel;
  logic                r_htrans1;
  logic                r_hwrite;
  reg_idx_t            r_haddr;
  logic [WIDTH-1:0]    r_sync [SYNC_STAGES];
  logic [DB_CNT_W-1:0] r_tick_cnt;
  logic [WIDTH-1:0]    r_irq_en;
  logic [WIDTH-1:0]    r_status;
  logic                r_irq;

  logic                w_wr_en;
  logic [WIDTH-1:0]    w_wdata;
  logic [WIDTH-1:0]    w_raw;
  logic                w_tick;
  logic [WIDTH-1:0]    w_stable;
  logic [WIDTH-1:0]    w_change;
  logic [WIDTH-1:0]    w_clr;
  logic                w_unused;

  // Address bits, size and the upper write-data bits carry no meaning here.
  assign w_unused = ^{HADDR[31:4], HADDR[1:0], HTRANS[0], HSIZE, HWDATA};

  // Capture the address phase whenever the bus is ready.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_hsel    <= 1'b0;
      r_htrans1 <= 1'b0;
      r_hwrite  <= 1'b0;
      r_haddr   <= REG_DATA;
    end else if (HREADY) begin
      r_hsel    <= HSEL;
      r_htrans1 <= HTRANS[1];
      r_hwrite  <= HWRITE;
      r_haddr   <= reg_idx_t'(HADDR[3:2]);
    end
  end

  assign w_wr_en = r_hsel & r_hwrite & r_htrans1;
  assign w_wdata = HWDATA[WIDTH-1:0];

  // Multi-flop synchroniser bringing the pins into the HCLK domain.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= Switches;
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign w_raw  = r_sync[SYNC_STAGES-1];
  assign w_tick = (r_tick_cnt == DB_CNT_W'(DB_PERIOD - 1));

  // Free-running sample-tick counter, wrapping after DB_PERIOD cycles.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)    r_tick_cnt <= '0;
    else if (w_tick) r_tick_cnt <= '0;
    else             r_tick_cnt <= r_tick_cnt + DB_CNT_W'(1);
  end

  switch_debounce #(
    .WIDTH (WIDTH)
  ) u_debounce (
    .i_clk    (HCLK),
    .i_rst_n  (HRESETn),
    .i_raw    (w_raw),
    .i_tick   (w_tick),
    .o_stable (w_stable),
    .o_change (w_change)
  );

  assign w_clr = (w_wr_en && r_haddr == REG_STATUS) ? w_wdata : '0;

  // Register file: interrupt enable and sticky change flags (set beats clear).
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_irq_en <= '0;
      r_status <= '0;
    end else begin
      if (w_wr_en && r_haddr == REG_IRQ_EN) r_irq_en <= w_wdata;
      r_status <= (r_status & ~w_clr) | w_change;
    end
  end

  // Registered level interrupt from enabled change flags.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_irq <= 1'b0;
    else          r_irq <= |(r_status & r_irq_en);
  end

  // Read mux driven from the registered address, independent of select.
  always_comb begin
    HRDATA = '0;
    case (r_haddr)
      REG_DATA:   HRDATA[WIDTH-1:0] = w_stable;
      REG_RAW:    HRDATA[WIDTH-1:0] = w_raw;
      REG_IRQ_EN: HRDATA[WIDTH-1:0] = r_irq_en;
      REG_STATUS: HRDATA[WIDTH-1:0] = r_status;
      default:    HRDATA = '0;
    endcase
  end

  assign HREADYOUT = 1'b1;
  assign IRQ       = r_irq;

endmodule

// File: tb/tb_ahb_switch_in.sv
// Randomised bench for ahb_switch_in with a queue-based behavioural model.
module tb_ahb_switch_in;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int P  = 4;
  localparam int CW = 3;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          HSEL = 1'b0;
  logic          HREADY = 1'b1;
  logic [31:0]   HADDR = '0;
  logic [1:0]    HTRANS = 2'b00;
  logic          HWRITE = 1'b0;
  logic [2:0]    HSIZE = 3'd2;
  logic [31:0]   HWDATA = '0;
  logic          HREADYOUT;
  logic [31:0]   HRDATA;
  logic [W-1:0]  Switches = '0;
  logic          IRQ;

  int total = 0;
  int bad   = 0;

  ahb_switch_in #(
    .WIDTH(W), .SYNC_STAGES(S), .DB_PERIOD(P), .DB_CNT_W(CW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HREADY(HREADY),
    .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA),
    .Switches(Switches), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural model state
  int           m_edges;
  logic [W-1:0] m_pq[$];
  logic [W-1:0] m_raw, m_s1, m_s0, m_stable, m_pending, m_status, m_en;
  logic         m_irq, m_sel, m_trans, m_wr;
  logic [1:0]   m_addr;

  function automatic logic [31:0] model_rd();
    logic [31:0] v;
    v = '0;
    case (m_addr)
      2'd0: v[W-1:0] = m_stable;
      2'd1: v[W-1:0] = m_raw;
      2'd2: v[W-1:0] = m_en;
      default: v[W-1:0] = m_status;
    endcase
    return v;
  endfunction

  always @(posedge HCLK) begin : model
    logic [W-1:0] clr, en_n, st_n, stat_n, mask;
    logic irq_n, tick, wr;
    if (!HRESETn) begin
      m_edges = 0;
      m_pq.delete();
      for (int i = 0; i < S; i++) m_pq.push_back('0);
      m_raw = '0; m_s1 = '0; m_s0 = '0; m_stable = '0; m_pending = '0;
      m_status = '0; m_en = '0; m_irq = 1'b0;
      m_sel = 1'b0; m_trans = 1'b0; m_wr = 1'b0; m_addr = 2'd0;
    end else begin
      tick = ((m_edges % P) == P - 1);
      wr   = m_sel & m_wr & m_trans;
      clr  = (wr && m_addr == 2'd3) ? HWDATA[W-1:0] : '0;
      en_n = (wr && m_addr == 2'd2) ? HWDATA[W-1:0] : m_en;
      irq_n  = |(m_status & m_en);
      stat_n = (m_status & ~clr) | m_pending;
      st_n   = m_stable;
      if (tick) begin
        mask = ~(m_raw ^ m_s1) & ~(m_raw ^ m_s0);
        st_n = (m_stable & ~mask) | (m_raw & mask);
        m_s0 = m_s1;
        m_s1 = m_raw;
      end
      m_pending = st_n ^ m_stable;
      m_stable  = st_n;
      m_status  = stat_n;
      m_en      = en_n;
      m_irq     = irq_n;
      m_pq.push_back(Switches);
      void'(m_pq.pop_front());
      m_raw = m_pq[0];
      if (HREADY) begin
        m_sel = HSEL; m_trans = HTRANS[1]; m_wr = HWRITE; m_addr = HADDR[3:2];
      end
      m_edges++;
    end
    #1;
    check_val("HRDATA", HRDATA, model_rd());
    check_val("IRQ", {31'b0, IRQ}, {31'b0, m_irq});
    check_val("HREADYOUT", {31'b0, HREADYOUT}, 32'd1);
  end

  // Called at a negedge; returns at the next negedge with the data phase driven.
  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    HREADY = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = {28'b0, a, 2'b00};
    @(negedge HCLK);
    HWDATA = d; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    HREADY = 1'b1; HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0;
    HADDR = {28'b0, a, 2'b00};
    @(negedge HCLK);
    HSEL = 1'b0; HTRANS = 2'b00;
    d = HRDATA;
  endtask

  initial begin : stim
    logic [31:0] d, d0, r0;
    int found, cyc;

    // Reset state
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    bus_read(2'd0, d); check_val("rst_data", d, 32'h0);
    bus_read(2'd1, d); check_val("rst_raw", d, 32'h0);
    bus_read(2'd3, d); check_val("rst_status", d, 32'h0);
    check_val("rst_irq", {31'b0, IRQ}, 32'h0);

    // Debounce a held pattern
    Switches = 8'hA5;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h0;
    found = 0; cyc = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge HCLK);
      if (HRDATA == 32'hA5) begin found = 1; cyc = i; break; end
    end
    check_val("data_a5_in_time", {31'b0, (found == 1 && cyc <= 14)}, 32'd1);
    HSEL = 1'b0; HTRANS = 2'b00;
    repeat (3) @(negedge HCLK);
    bus_read(2'd1, d); check_val("raw_a5", d, 32'hA5);
    bus_read(2'd3, d); check_val("status_a5", d, 32'hA5);
    check_val("irq_masked", {31'b0, IRQ}, 32'h0);

    // Short glitch on a low bit is rejected
    bus_write(2'd3, 32'hFF);
    @(negedge HCLK);
    Switches = 8'hA7;
    repeat (3) @(negedge HCLK);
    Switches = 8'hA5;
    repeat (20) @(negedge HCLK);
    bus_read(2'd0, d); check_val("glitch_data", d, 32'hA5);
    bus_read(2'd3, d); check_val("glitch_status", d, 32'h0);

    // Enabled interrupt on a falling edge, then W1C
    bus_write(2'd2, 32'h1);
    bus_write(2'd3, 32'hFF);
    Switches = 8'hA4;
    repeat (20) @(negedge HCLK);
    bus_read(2'd3, d); check_val("status_fall", d, 32'h1);
    check_val("irq_set", {31'b0, IRQ}, 32'd1);
    bus_write(2'd3, 32'h1);
    @(negedge HCLK);
    check_val("irq_hold", {31'b0, IRQ}, 32'd1);
    @(negedge HCLK);
    check_val("irq_clear", {31'b0, IRQ}, 32'd0);

    // Clear and set of bit0 in the same cycle
    Switches = 8'hA5;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge HCLK);
      if (((m_edges % P) == P - 1) && m_raw[0] == m_s1[0] && m_raw[0] == m_s0[0]
          && m_stable[0] != m_raw[0]) begin
        found = 1;
        break;
      end
    end
    check_val("collide_found", found, 1);
    bus_write(2'd3, 32'h1);
    @(negedge HCLK);
    bus_read(2'd3, d); check_val("set_wins", {31'b0, d[0]}, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(negedge HCLK);
      if ($urandom_range(0, 15) == 0) Switches = W'($urandom);
      HREADY = ($urandom_range(0, 3) != 0);
      HSEL   = $urandom_range(0, 1);
      HTRANS = 2'($urandom);
      HWRITE = $urandom_range(0, 1);
      HADDR  = $urandom;
      HWDATA = $urandom;
    end
    @(negedge HCLK);
    HREADY = 1'b1; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    Switches = 8'hFF;
    repeat (20) @(negedge HCLK);

    // Writes to read-only offsets are ignored
    bus_read(2'd0, d0);
    bus_read(2'd1, r0);
    bus_write(2'd0, 32'h00);
    bus_write(2'd1, 32'h00);
    @(negedge HCLK);
    bus_read(2'd0, d); check_val("ro_data", d, d0);
    bus_read(2'd1, d); check_val("ro_raw", d, r0);
    check_val("data_ff", d0, 32'hFF);

    // Reset during a data phase
    bus_write(2'd2, 32'h5A);
    bus_write(2'd3, 32'h00);
    HRESETn = 1'b0;
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    bus_read(2'd2, d); check_val("rst2_irq_en", d, 32'h0);
    bus_read(2'd3, d); check_val("rst2_status", d, 32'h0);
    bus_read(2'd0, d); check_val("rst2_data", d, 32'h0);
    check_val("rst2_irq", {31'b0, IRQ}, 32'h0);
    repeat (2) @(negedge HCLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
